// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding and parity constants shared by transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, tick on the last clock of each serial bit
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // With one clock per bit CNT_LAST is 0, so the counter never leaves 0 and tick stays high.
    assign tick = (r_cnt == CNT_LAST);

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n || clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with ready/valid word input
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 tx_data_valid,
    input  logic [DATA_BITS-1:0] in,
    output logic                 tx_ready,
    output logic                 tx_active,
    output logic                 tx_serial_data,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks
            $error("uart_tx_cfg: CLKS_PER_BIT must be 1..65535");
        end
    endgenerate

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_par;
    logic                 r_line;
    logic                 r_active;
    logic                 r_done;
    logic                 w_clr;
    logic                 w_tick;

    // Holding the bit timer in clear while idle makes every bit start a full period after accept.
    assign w_clr = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .clr    (w_clr),
        .tick   (w_tick)
    );

    assign tx_ready       = (r_state == IDLE) && i_Rst_n;
    assign tx_active      = r_active;
    assign tx_serial_data = r_line;
    assign tx_done        = r_done;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_line    <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_data_valid) begin
                        r_shift   <= in;
                        r_bit_cnt <= '0;
                        r_par     <= 1'b0;
                        r_line    <= 1'b0;
                        r_active  <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_line    <= r_shift[0];
                        r_par     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= BIT_W'(1);
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        // r_bit_cnt counts data bits already placed on the line.
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_line  <= (PARITY == PAR_ODD) ? ~r_par : r_par;
                                r_state <= uart_pkg::PARITY;
                            end else begin
                                r_line  <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_line    <= r_shift[0];
                            r_par     <= r_par ^ r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_tick) begin
                        r_line    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= '0;
                            r_active  <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_line    <= 1'b1;
                    r_active  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg over five configurations
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst_n;
    logic [4:0] valid;
    logic [8:0] data [5];
    logic [4:0] line;
    logic [4:0] active;
    logic [4:0] done;
    logic [4:0] ready;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 4 clk/bit 8N1   1: 4 clk/bit 8E1   2: 4 clk/bit 8O1   3: 4 clk/bit 7N2   4: 1 clk/bit 8E1
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .tx_data_valid(valid[0]), .in(data[0][7:0]),
        .tx_ready(ready[0]), .tx_active(active[0]), .tx_serial_data(line[0]), .tx_done(done[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .tx_data_valid(valid[1]), .in(data[1][7:0]),
        .tx_ready(ready[1]), .tx_active(active[1]), .tx_serial_data(line[1]), .tx_done(done[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .tx_data_valid(valid[2]), .in(data[2][7:0]),
        .tx_ready(ready[2]), .tx_active(active[2]), .tx_serial_data(line[2]), .tx_done(done[2]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .i_Clock(clk), .i_Rst_n(rst_n), .tx_data_valid(valid[3]), .in(data[3][6:0]),
        .tx_ready(ready[3]), .tx_active(active[3]), .tx_serial_data(line[3]), .tx_done(done[3]));

    uart_tx_cfg #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1_fast (
        .i_Clock(clk), .i_Rst_n(rst_n), .tx_data_valid(valid[4]), .in(data[4][7:0]),
        .tx_ready(ready[4]), .tx_active(active[4]), .tx_serial_data(line[4]), .tx_done(done[4]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accept edge; samples len+1 negedges (frame plus the tx_done clock).
    task automatic capture_frame(input int k, input logic [8:0] word, input int nb,
                                 input bit has_par, input logic pbit, input int stops,
                                 input int cpb, input int len, input string tag, input bit poke);
        logic        seq [16];
        logic [63:0] exp_line, obs_line, obs_act, obs_done;
        int          n;
        n = 0;
        seq[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin seq[n] = word[i]; n++; end
        if (has_par) begin seq[n] = pbit; n++; end
        for (int i = 0; i < stops; i++) begin seq[n] = 1'b1; n++; end
        exp_line = '0; obs_line = '0; obs_act = '0; obs_done = '0;
        for (int c = 0; c < len; c++) exp_line[c] = seq[c / cpb];
        exp_line[len] = 1'b1;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            obs_line[c] = line[k];
            obs_act[c]  = active[k];
            obs_done[c] = done[k];
            if (poke && c == len / 2) begin
                valid[k] = 1'b1;
                data[k]  = ~word;
            end
            if (poke && c == len / 2 + 2) valid[k] = 1'b0;
        end
        check({tag, "_line"}, obs_line, exp_line);
        check({tag, "_active"}, obs_act, (64'd1 << len) - 64'd1);
        check({tag, "_done"}, obs_done, 64'd1 << len);
        check({tag, "_ready_end"}, 64'(ready[k]), 64'd1);
    endtask

    task automatic send(input int k, input logic [8:0] word, input int nb,
                        input bit has_par, input logic pbit, input int stops,
                        input int cpb, input int len, input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 64'(ready[k]), 64'd1);
        valid[k] = 1'b1;
        data[k]  = word;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        data[k]  = ~word;
        capture_frame(k, word, nb, has_par, pbit, stops, cpb, len, tag, 1'b1);
        @(negedge clk);
        check({tag, "_done_clr"}, 64'(done[k]), 64'd0);
    endtask

    initial begin
        logic [63:0] seen_done;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        valid    = '0;
        for (int i = 0; i < 5; i++) data[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line", 64'(line), 64'h1f);
        check("rst_active", 64'(active), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_ready", 64'(ready), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 64'h1f);

        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 4, 40, "a5_8n1");
        send(1, 9'h007, 8, 1'b1, 1'b1, 1, 4, 44, "07_even");
        send(2, 9'h007, 8, 1'b1, 1'b0, 1, 4, 44, "07_odd");
        send(3, 9'h07F, 7, 1'b0, 1'b0, 2, 4, 40, "7f_7n2");
        send(4, 9'h000, 8, 1'b1, 1'b0, 1, 1, 11, "00_8e1_cpb1");

        // Back-to-back: valid stays high, second word waits for the tx_done clock.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h012;
        @(posedge clk);
        #1;
        data[0] = 9'h034;
        capture_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 4, 40, "b2b_12", 1'b0);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        data[0]  = 9'h0FF;
        capture_frame(0, 9'h034, 8, 1'b0, 1'b0, 1, 4, 40, "b2b_34", 1'b0);
        @(negedge clk);
        check("b2b_done_clr", 64'(done[0]), 64'd0);

        // Reset during data bit 3 (frame clocks 16..19).
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h0C3;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_line", 64'(line[0]), 64'd1);
        check("abort_active", 64'(active[0]), 64'd0);
        check("abort_ready", 64'(ready[0]), 64'd1);
        seen_done = '0;
        for (int c = 0; c < 48; c++) begin
            seen_done[c] = done[0] | line[0] ~^ 1'b0;
            @(negedge clk);
        end
        check("abort_no_done_line_high", seen_done, 64'd0);

        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 4, 40, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
